// File: rtl/adder_arb_pkg.sv
// Shared definitions for the adder arbiter: FSM state encoding, default
// datapath widths and the grant-statistics counter width.
package adder_arb_pkg;

  // FSM encoding is fixed so that state values are stable across builds.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    CAPT = 2'd2,
    RESP = 2'd3
  } arb_state_t;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_OP_WIDTH  = 3;
  localparam int DEF_RES_WIDTH = 20;
  localparam int GCNT_W        = 16;

  localparam logic [GCNT_W-1:0] GCNT_MAX = '1;

  // Saturating increment for the per-requester grant counters.
  function automatic logic [GCNT_W-1:0] sat_inc(input logic [GCNT_W-1:0] v);
    return (v == GCNT_MAX) ? v : v + GCNT_W'(1);
  endfunction

endpackage

// File: rtl/adder_arbiter_rr_pick.sv
// Combinational round-robin picker. Searches the request vector starting at
// (last + 1) mod NREQ and returns the first set bit as a one-hot grant and as
// an index, plus a flag saying whether any request was present.
module rr_pick #(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  // Candidate k is the requester k+1 positions after the last winner.
  logic [IDW-1:0]  cand_idx [NREQ];
  logic [NREQ-1:0] cand_v;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
    logic [IDW:0] sum;
    // One extra bit is enough: sum never reaches 2*NREQ, so a single
    // conditional subtract implements the modulo for any NREQ.
    assign sum          = {1'b0, last} + (IDW+1)'(gi + 1);
    assign cand_idx[gi] = (sum >= (IDW+1)'(NREQ)) ? IDW'(sum - (IDW+1)'(NREQ))
                                                  : sum[IDW-1:0];
    assign cand_v[gi]   = req[cand_idx[gi]];
  end

  // First valid candidate in rotated order wins.
  always_comb begin
    any   = 1'b0;
    idx   = '0;
    grant = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (cand_v[k] && !any) begin
        any = 1'b1;
        idx = cand_idx[k];
      end
    end
    if (any) begin
      grant = NREQ'(1) << idx;
    end
  end

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin sequencer that shares one registered adder datapath among NREQ
// requesters. One request is granted at a time, its operands are registered
// onto the datapath, the result is captured after DP_LAT cycles and returned
// with the requester id over a valid/ready response channel.
// Optional feature macro: ADDER_ARB_STATS_EN adds per-requester saturating
// 16-bit grant counters on output grant_cnt.
module adder_arbiter
  import adder_arb_pkg::*;
#(
  parameter  int NREQ      = 4,
  parameter  int WIDTH     = DEF_WIDTH,
  parameter  int OP_WIDTH  = DEF_OP_WIDTH,
  parameter  int RES_WIDTH = DEF_RES_WIDTH,
  parameter  int DP_LAT    = 1,
  localparam int IDW       = $clog2(NREQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*WIDTH-1:0]    req_a,
  input  logic [NREQ*WIDTH-1:0]    req_b,
  input  logic [NREQ*OP_WIDTH-1:0] req_op,
  input  logic [NREQ-1:0]          req_mode,
  output logic [WIDTH-1:0]         dp_a,
  output logic [WIDTH-1:0]         dp_b,
  output logic [OP_WIDTH-1:0]      dp_op,
  output logic                     dp_mode,
  input  logic [RES_WIDTH-1:0]     dp_result,
  input  logic                     dp_flag,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [IDW-1:0]           rsp_id,
  output logic [RES_WIDTH-1:0]     rsp_result,
  output logic                     rsp_flag,
  output logic                     busy
`ifdef ADDER_ARB_STATS_EN
  ,
  output logic [NREQ*GCNT_W-1:0]   grant_cnt
`endif
);

  // Latency counter only needs to reach DP_LAT-1.
  localparam int CW = (DP_LAT > 1) ? $clog2(DP_LAT) : 1;

  arb_state_t      state_reg, state_next;
  logic [IDW-1:0]  last_grant_reg;
  logic [CW-1:0]   cnt_reg;

  logic [NREQ-1:0] pick_grant;
  logic [IDW-1:0]  pick_idx;
  logic            pick_any;
  logic            grant_fire;
  logic            dp_done;

  rr_pick #(
    .NREQ (NREQ)
  ) u_pick (
    .req   (req_valid),
    .last  (last_grant_reg),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // A grant happens only from IDLE; the response handshake cycle is RESP, so
  // the next grant is naturally one cycle after the response is accepted.
  assign grant_fire = (state_reg == IDLE) && pick_any;
  assign dp_done    = (cnt_reg == CW'(DP_LAT - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_next = state_reg;
    req_ready  = '0;
    rsp_valid  = 1'b0;
    busy       = 1'b1;
    case (state_reg)
      IDLE: begin
        busy = 1'b0;
        if (pick_any) begin
          req_ready  = pick_grant;
          state_next = EXEC;
        end
      end
      EXEC: begin
        if (dp_done) begin
          state_next = CAPT;
        end
      end
      CAPT: begin
        state_next = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath latency counter, active only while waiting in EXEC.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (state_reg == EXEC) begin
      cnt_reg <= dp_done ? '0 : cnt_reg + CW'(1);
    end else begin
      cnt_reg <= '0;
    end
  end

  // Latch the winner's operands and id on the grant edge; they stay stable
  // until the next grant so the datapath sees constant inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      dp_a           <= '0;
      dp_b           <= '0;
      dp_op          <= '0;
      dp_mode        <= 1'b0;
      rsp_id         <= '0;
      last_grant_reg <= IDW'(NREQ - 1);
    end else if (grant_fire) begin
      dp_a           <= req_a[pick_idx*WIDTH +: WIDTH];
      dp_b           <= req_b[pick_idx*WIDTH +: WIDTH];
      dp_op          <= req_op[pick_idx*OP_WIDTH +: OP_WIDTH];
      dp_mode        <= req_mode[pick_idx];
      rsp_id         <= pick_idx;
      last_grant_reg <= pick_idx;
    end
  end

  // Capture the datapath result once the latency has elapsed.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_result <= '0;
      rsp_flag   <= 1'b0;
    end else if (state_reg == CAPT) begin
      rsp_result <= dp_result;
      rsp_flag   <= dp_flag;
    end
  end

`ifdef ADDER_ARB_STATS_EN
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_stats
    logic [GCNT_W-1:0] gcnt_reg;
    // Count grants to requester gi, sticking at the maximum value.
    always_ff @(posedge clk) begin
      if (rst) begin
        gcnt_reg <= '0;
      end else if (grant_fire && pick_grant[gi]) begin
        gcnt_reg <= sat_inc(gcnt_reg);
      end
    end
    assign grant_cnt[gi*GCNT_W +: GCNT_W] = gcnt_reg;
  end
`endif

endmodule
